// File: rtl/liteic_pkg.sv
// Shared liteic interconnect widths and the slave write-node state type.
package liteic_pkg;

    localparam int IC_NUM_MASTER_SLOTS = 4;
    localparam int IC_AWADDR_WIDTH     = 24;
    localparam int IC_AW_OFFSET_WIDTH  = IC_AWADDR_WIDTH - 12;
    localparam int IC_AXIL_ADDR_WIDTH  = 20;
    localparam int IC_DATA_WIDTH       = 32;
    localparam int IC_STRB_WIDTH       = IC_DATA_WIDTH / 8;
    localparam int IC_WDATA_WIDTH      = IC_STRB_WIDTH + IC_DATA_WIDTH;
    localparam int IC_BRESP_WIDTH      = 2;

    typedef enum logic [1:0] {
        IDLE,
        XFER,
        RESP
    } wr_state_t;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/axi_lite_if_20bit_addr.sv
// AXI-Lite write channels with a 20-bit address.
interface axi_lite_if_20bit_addr;
    import liteic_pkg::*;

    logic                          aw_valid;
    logic                          aw_ready;
    logic [IC_AXIL_ADDR_WIDTH-1:0] aw_addr;
    logic                          w_valid;
    logic                          w_ready;
    logic [IC_DATA_WIDTH-1:0]      w_data;
    logic [IC_STRB_WIDTH-1:0]      w_strb;
    logic                          b_valid;
    logic                          b_ready;
    logic [IC_BRESP_WIDTH-1:0]     b_resp;

    modport master (
        output aw_valid, aw_addr, w_valid, w_data, w_strb, b_ready,
        input  aw_ready, w_ready, b_valid, b_resp
    );

    modport slave (
        input  aw_valid, aw_addr, w_valid, w_data, w_strb, b_ready,
        output aw_ready, w_ready, b_valid, b_resp
    );

endinterface

// File: rtl/liteic_rr_arbiter.sv
// Combinational round-robin pick: first request at or after ptr wins.
module liteic_rr_arbiter
    import liteic_pkg::*;
#(
    parameter  int N  = IC_NUM_MASTER_SLOTS,
    localparam int IW = idx_width(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx,
    output logic          any
);

    int slot;

    // Walk from farthest to nearest so the slot at ptr overwrites last.
    always_comb begin
        gnt  = '0;
        idx  = '0;
        slot = 0;
        for (int i = N - 1; i >= 0; i--) begin
            slot = (int'(ptr) + i) % N;
            if (req[slot]) begin
                gnt       = '0;
                gnt[slot] = 1'b1;
                idx       = IW'(slot);
            end
        end
        any = |req;
    end

endmodule

// File: rtl/liteic_slave_node_write.sv
// Slave-side write node: arbitrates masters, runs one AW/W/B at a time.
module liteic_slave_node_write
    import liteic_pkg::*;
#(
    parameter int                     NUM_MASTERS     = IC_NUM_MASTER_SLOTS,
    parameter logic [NUM_MASTERS-1:0] WR_CONNECTIVITY = '1
) (
    input  logic                                     clk_i,
    input  logic                                     rst_i,
    input  logic [NUM_MASTERS-1:0]                   cbar_aw_reqst_val_i,
    input  logic [NUM_MASTERS*IC_AW_OFFSET_WIDTH-1:0] cbar_aw_reqst_data_i,
    output logic [NUM_MASTERS-1:0]                   cbar_aw_reqst_rdy_o,
    input  logic [NUM_MASTERS-1:0]                   cbar_w_reqst_val_i,
    input  logic [NUM_MASTERS*IC_WDATA_WIDTH-1:0]    cbar_w_reqst_data_i,
    output logic [NUM_MASTERS-1:0]                   cbar_w_reqst_rdy_o,
    output logic [NUM_MASTERS-1:0]                   cbar_resp_val_o,
    output logic [NUM_MASTERS*IC_BRESP_WIDTH-1:0]    cbar_resp_data_o,
    input  logic [NUM_MASTERS-1:0]                   cbar_resp_rdy_i,
    axi_lite_if_20bit_addr.master                    slv_axil
);

    localparam int IW = idx_width(NUM_MASTERS);
    localparam int OW = IC_AW_OFFSET_WIDTH;
    localparam int DW = IC_WDATA_WIDTH;
    localparam int BW = IC_BRESP_WIDTH;

    wr_state_t              state;
    wr_state_t              next;
    logic [IW-1:0]          rr_ptr;
    logic [NUM_MASTERS-1:0] grant_r;
    logic [IW-1:0]          idx_r;
    logic [OW-1:0]          addr_r;
    logic                   aw_done;
    logic                   w_done;

    logic [NUM_MASTERS-1:0] req;
    logic [NUM_MASTERS-1:0] arb_gnt;
    logic [IW-1:0]          arb_idx;
    logic                   arb_any;
    logic [OW-1:0]          win_addr;
    logic                   gw_val;
    logic [DW-1:0]          gw_data;
    logic                   aw_hs;
    logic                   w_hs;
    logic                   b_hs;

    assign req    = cbar_aw_reqst_val_i & WR_CONNECTIVITY;
    assign gw_val = |(cbar_w_reqst_val_i & grant_r);

    liteic_rr_arbiter #(.N(NUM_MASTERS)) u_arb (
        .req (req),
        .ptr (rr_ptr),
        .gnt (arb_gnt),
        .idx (arb_idx),
        .any (arb_any)
    );

    always_comb begin
        win_addr = '0;
        gw_data  = '0;
        for (int m = 0; m < NUM_MASTERS; m++) begin
            if (arb_gnt[m]) win_addr |= cbar_aw_reqst_data_i[m*OW +: OW];
            if (grant_r[m]) gw_data  |= cbar_w_reqst_data_i[m*DW +: DW];
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state <= IDLE;
        else       state <= next;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rr_ptr  <= '0;
            grant_r <= '0;
            idx_r   <= '0;
            addr_r  <= '0;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: if (arb_any) begin
                    grant_r <= arb_gnt;
                    idx_r   <= arb_idx;
                    addr_r  <= win_addr;
                end
                XFER: begin
                    if (aw_hs) aw_done <= 1'b1;
                    if (w_hs)  w_done  <= 1'b1;
                end
                RESP: if (b_hs) begin
                    aw_done <= 1'b0;
                    w_done  <= 1'b0;
                    grant_r <= '0;
                    rr_ptr  <= (idx_r == IW'(NUM_MASTERS - 1)) ? '0 : idx_r + 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        next = state;
        unique case (state)
            IDLE:    if (arb_any) next = XFER;
            XFER:    if ((aw_done || aw_hs) && (w_done || w_hs)) next = RESP;
            RESP:    if (b_hs) next = IDLE;
            default: next = IDLE;
        endcase
    end

    always_comb begin
        cbar_aw_reqst_rdy_o = '0;
        cbar_w_reqst_rdy_o  = '0;
        cbar_resp_val_o     = '0;
        cbar_resp_data_o    = '0;
        slv_axil.aw_valid   = 1'b0;
        slv_axil.aw_addr    = '0;
        slv_axil.aw_addr[OW-1:0] = addr_r;
        slv_axil.w_valid    = 1'b0;
        slv_axil.w_data     = '0;
        slv_axil.w_strb     = '0;
        slv_axil.b_ready    = 1'b0;
        aw_hs = 1'b0;
        w_hs  = 1'b0;
        b_hs  = 1'b0;
        unique case (state)
            // Grant ready is combinational, so mask it while reset is held.
            IDLE: cbar_aw_reqst_rdy_o = arb_gnt & {NUM_MASTERS{!rst_i}};
            XFER: begin
                slv_axil.aw_valid = !aw_done;
                slv_axil.w_valid  = gw_val && !w_done;
                {slv_axil.w_strb, slv_axil.w_data} = gw_data;
                cbar_w_reqst_rdy_o =
                    grant_r & {NUM_MASTERS{slv_axil.w_ready && !w_done}};
                aw_hs = !aw_done && slv_axil.aw_ready;
                w_hs  = gw_val && !w_done && slv_axil.w_ready;
            end
            RESP: begin
                slv_axil.b_ready = |(cbar_resp_rdy_i & grant_r);
                cbar_resp_val_o  = grant_r & {NUM_MASTERS{slv_axil.b_valid}};
                for (int m = 0; m < NUM_MASTERS; m++) begin
                    if (WR_CONNECTIVITY[m])
                        cbar_resp_data_o[m*BW +: BW] = slv_axil.b_resp;
                end
                b_hs = slv_axil.b_valid && slv_axil.b_ready;
            end
            default: ;
        endcase
    end

endmodule
